// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial magnitude comparator: one shared 1-bit less-than cell walks the operands MSB first.
// Optional two's-complement ordering is enabled by defining SIGNED_CMP_EN (adds the signed_mode port).
module serial_mag_comparator_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;

    logic w_accept;
    logic w_bit_a;
    logic w_bit_b;
    logic w_cell_lt;
    logic w_cell_gt;
    logic w_swap;
    logic w_bit_lt;
    logic w_bit_gt;
    logic w_last;
    logic w_signed;

    logic w_busy_nxt;
    logic w_done_nxt;
    logic w_lt_nxt;
    logic w_eq_nxt;
    logic w_gt_nxt;

`ifdef SIGNED_CMP_EN
    logic r_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_signed <= signed_mode;
        end
    end

    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start;

    // Shared compare cell: the gt decision is the same cell with its inputs exchanged.
    always_comb begin
        w_bit_a   = r_a[r_idx];
        w_bit_b   = r_b[r_idx];
        w_cell_lt = ~w_bit_a & w_bit_b;
        w_cell_gt = w_bit_a & ~w_bit_b;
        w_swap    = w_signed && (r_idx == MSB_IDX);
        w_bit_lt  = w_swap ? w_cell_gt : w_cell_lt;
        w_bit_gt  = w_swap ? w_cell_lt : w_cell_gt;
        w_last    = (r_idx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_bit_lt || w_bit_gt || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; results hold until the next accepted start.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_lt_nxt   = lt;
        w_eq_nxt   = eq;
        w_gt_nxt   = gt;
        if (w_accept) begin
            w_lt_nxt = 1'b0;
            w_eq_nxt = 1'b0;
            w_gt_nxt = 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_bit_lt) begin
                w_lt_nxt = 1'b1;
            end else if (w_bit_gt) begin
                w_gt_nxt = 1'b1;
            end else if (w_last) begin
                w_eq_nxt = 1'b1;
            end
        end
    end

    // Operand latch and bit-index walk; index stops at 0 because the last bit always exits RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= MSB_IDX;
        end else if ((r_state == S_RUN) && !w_bit_lt && !w_bit_gt && !w_last) begin
            r_idx <= r_idx - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            lt   <= 1'b0;
            eq   <= 1'b0;
            gt   <= 1'b0;
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            lt   <= w_lt_nxt;
            eq   <= w_eq_nxt;
            gt   <= w_gt_nxt;
        end
    end

endmodule
